// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a programmable busy latency.
// Define MDU_MADD_EN to add the MADD/MSUB accumulate ops (op 110/111); otherwise those encodings are no-ops.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } op_t;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [W2-1:0]    pend, pend_next;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic             done_next;

    // Multiply: both products are formed at full 2*WIDTH width.
    logic signed [W2-1:0] a_ext, b_ext;
    logic [W2-1:0]        prod_s, prod_u;

    assign a_ext  = {{WIDTH{dataA[WIDTH-1]}}, dataA};
    assign b_ext  = {{WIDTH{dataB[WIDTH-1]}}, dataB};
    assign prod_s = a_ext * b_ext;
    assign prod_u = {{WIDTH{1'b0}}, dataA} * {{WIDTH{1'b0}}, dataB};

    // The divider never sees a zero or overflowing divisor; those cases are muxed in afterwards.
    logic                    div_zero, div_ovf;
    logic signed [WIDTH-1:0] sa, sb_safe, q_s, r_s;
    logic [WIDTH-1:0]        ub_safe;
    logic [W2-1:0]           div_s_res, div_u_res;

    assign div_zero  = (dataB == '0);
    assign div_ovf   = (dataA == {1'b1, {(WIDTH-1){1'b0}}}) && (dataB == '1);
    assign sa        = dataA;
    assign sb_safe   = (div_zero || div_ovf) ? WIDTH'(1) : dataB;
    assign ub_safe   = div_zero ? WIDTH'(1) : dataB;
    assign q_s       = sa / sb_safe;
    assign r_s       = sa % sb_safe;
    assign div_s_res = div_zero ? {dataA, {WIDTH{1'b1}}} :
                       div_ovf  ? {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}} :
                                  {r_s, q_s};
    assign div_u_res = div_zero ? {dataA, {WIDTH{1'b1}}} :
                                  {dataA % ub_safe, dataA / ub_safe};

`ifdef MDU_MADD_EN
    logic [W2-1:0] madd_res, msub_res;
    assign madd_res = {hi, lo} + prod_s;
    assign msub_res = {hi, lo} - prod_s;
`endif

    assign busy = (cnt != '0);

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latches).
        state_next = state;
        cnt_next   = cnt;
        pend_next  = pend;
        hi_next    = hi;
        lo_next    = lo;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op_t'(op))
                        OP_MULT:  begin pend_next = prod_s;    cnt_next = CNT_W'(MULT_CYCLES); state_next = RUN; end
                        OP_MULTU: begin pend_next = prod_u;    cnt_next = CNT_W'(MULT_CYCLES); state_next = RUN; end
                        OP_DIV:   begin pend_next = div_s_res; cnt_next = CNT_W'(DIV_CYCLES);  state_next = RUN; end
                        OP_DIVU:  begin pend_next = div_u_res; cnt_next = CNT_W'(DIV_CYCLES);  state_next = RUN; end
                        OP_MTHI:  hi_next = dataA;
                        OP_MTLO:  lo_next = dataA;
`ifdef MDU_MADD_EN
                        OP_MADD:  begin pend_next = madd_res;  cnt_next = CNT_W'(MULT_CYCLES); state_next = RUN; end
                        OP_MSUB:  begin pend_next = msub_res;  cnt_next = CNT_W'(MULT_CYCLES); state_next = RUN; end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    hi_next    = pend[W2-1:WIDTH];
                    lo_next    = pend[WIDTH-1:0];
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pend  <= pend_next;
            hi    <= hi_next;
            lo    <= lo_next;
            done  <= done_next;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases with literal expectations plus
// randomized traffic compared each cycle against a behavioural HI/LO model.
module tb_md_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] dataA = '0;
    logic [W-1:0] dataB = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic on 64-bit integers.
    function automatic logic [63:0] exp_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            3'b000: return sa * sb;
            3'b001: return ua * ub;
            3'b010: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'b011: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            3'b110:  return acc + sa * sb;
            3'b111:  return acc - sa * sb;
            default: return acc;
        endcase
    endfunction

    function automatic int cycles_of(input logic [2:0] o);
        case (o)
            3'b000, 3'b001: return MC;
            3'b010, 3'b011: return DC;
`ifdef MDU_MADD_EN
            3'b110, 3'b111: return MC;
`endif
            default: return 0;
        endcase
    endfunction

    logic [63:0] m_acc, m_pend;
    int          m_left;
    logic        m_done;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_acc  <= '0;
            m_pend <= '0;
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_left == 0) begin
            m_done <= 1'b0;
            if (start) begin
                if (op == 3'b100)      m_acc[63:32] <= dataA;
                else if (op == 3'b101) m_acc[31:0]  <= dataA;
                else if (cycles_of(op) != 0) begin
                    m_pend <= exp_result(op, dataA, dataB, m_acc);
                    m_left <= cycles_of(op);
                end
            end
        end else begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_acc <= m_pend;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("cyc_busy", {63'b0, busy}, {63'b0, m_left != 0});
            check("cyc_done", {63'b0, done}, {63'b0, m_done});
            check("cyc_hi", {32'b0, hi}, {32'b0, m_acc[63:32]});
            check("cyc_lo", {32'b0, lo}, {32'b0, m_acc[31:0]});
        end
    end

    task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; dataA = a; dataB = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        pulse(o, a, b);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("busy_timeout", 64'd1, 64'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        #2 reset_n = 1'b0;
        #1;
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        issue(3'b000, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("mult_busy_cycles", 64'(n), 64'd5);
        check("mult_done", {63'b0, done}, 64'd1);
        check("mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        check("mult_lo", {32'b0, lo}, 64'hFFFF_FFFA);
        @(negedge clk);
        check("mult_done_once", {63'b0, done}, 64'd0);

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        check("multu_busy_cycles", 64'(n), 64'd5);
        check("multu_hi", {32'b0, hi}, 64'hFFFF_FFFE);
        check("multu_lo", {32'b0, lo}, 64'h0000_0001);

        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_busy_cycles", 64'(n), 64'd10);
        check("div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
        check("div_hi", {32'b0, hi}, 64'hFFFF_FFFF);

        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("div_ovf_lo", {32'b0, lo}, 64'h8000_0000);
        check("div_ovf_hi", {32'b0, hi}, 64'h0);

        issue(3'b011, 32'd5, 32'd0);
        wait_idle(n);
        check("divu_zero_busy_cycles", 64'(n), 64'd10);
        check("divu_zero_lo", {32'b0, lo}, 64'hFFFF_FFFF);
        check("divu_zero_hi", {32'b0, hi}, 64'd5);

        issue(3'b100, 32'h1234, 32'd0);
        check("mthi_hi", {32'b0, hi}, 64'h1234);
        check("mthi_busy", {63'b0, busy}, 64'd0);
        issue(3'b101, 32'h5678, 32'd0);
        check("mtlo_lo", {32'b0, lo}, 64'h5678);
        check("mtlo_busy", {63'b0, busy}, 64'd0);

        // Starts during busy must be ignored; a start in the done cycle is accepted.
        issue(3'b000, 32'd7, 32'd6);
        pulse(3'b011, 32'd9, 32'd3);
        pulse(3'b100, 32'hDEAD, 32'd0);
        wait_idle(n);
        check("ignore_hi", {32'b0, hi}, 64'd0);
        check("ignore_lo", {32'b0, lo}, 64'd42);
        check("ignore_done", {63'b0, done}, 64'd1);
        pulse(3'b011, 32'd9, 32'd3);
        check("done_cycle_accept", {63'b0, busy}, 64'd1);
        wait_idle(n);
        check("done_cycle_busy", 64'(n), 64'd10);
        check("done_cycle_lo", {32'b0, lo}, 64'd3);
        check("done_cycle_hi", {32'b0, hi}, 64'd0);

`ifdef MDU_MADD_EN
        issue(3'b101, 32'd10, 32'd0);
        issue(3'b100, 32'd0, 32'd0);
        issue(3'b110, 32'd3, 32'd4);
        wait_idle(n);
        check("madd_busy_cycles", 64'(n), 64'd5);
        check("madd_lo", {32'b0, lo}, 64'd22);
        check("madd_hi", {32'b0, hi}, 64'd0);
        issue(3'b111, 32'd5, 32'd5);
        wait_idle(n);
        check("msub_lo", {32'b0, lo}, 64'hFFFF_FFFD);
        check("msub_hi", {32'b0, hi}, 64'hFFFF_FFFF);
`else
        issue(3'b110, 32'd7, 32'd7);
        check("noop110_busy", {63'b0, busy}, 64'd0);
        issue(3'b111, 32'd7, 32'd7);
        check("noop111_busy", {63'b0, busy}, 64'd0);
        check("noop_lo", {32'b0, lo}, 64'd3);
        check("noop_hi", {32'b0, hi}, 64'd0);
`endif

        // Asynchronous reset in the middle of a divide aborts it.
        issue(3'b011, 32'd5, 32'd0);
        wait_idle(n);
        issue(3'b010, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        check("pre_rst_hi", {32'b0, hi}, 64'd5);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_hi", {32'b0, hi}, 64'd0);
        check("midrst_lo", {32'b0, lo}, 64'd0);
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_hi", {32'b0, hi}, 64'd0);
        check("abort_lo", {32'b0, lo}, 64'd0);

        repeat (600) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            dataA = rand_operand();
            dataB = rand_operand();
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers. Next generation of the single-cycle combinational ALU.
- Sits in the EX stage beside the ALU. Accepts one operation per `start` pulse and raises `busy` for a programmable latency.
- The pipeline controller stalls any dependent instruction while `busy` is high.
- Services MIPS mult/multu/div/divu/mthi/mtlo, plus optional madd/msub.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for multiply ops; must be ≥1.
- DIV_CYCLES, 10, busy cycles for divide ops; must be ≥1.
- CNT_W, 8, width of the internal latency counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled at the clk rising edge.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- dataA  in  WIDTH  operand A (rs).
- dataB  in  WIDTH  operand B (rt).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by a multi-cycle op.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (reset_n), clock is clk.
  - reset_n=0 immediately clears hi, lo, busy, done, the counter and the pending result to 0.
  - Reset mid-operation aborts the operation; no HI/LO write occurs.
- Acceptance: `start`=1 with `busy`=0 at a rising edge accepts `op`. `start` while `busy`=1 is ignored entirely; the controller must stall instead.
- MTHI/MTLO:
  - Write `dataA` into hi (or lo) at the accepting edge.
  - `busy` and `done` stay 0.
- Multi-cycle ops (MULT/MULTU/DIV/DIVU and enabled MADD/MSUB):
  - At the accepting edge, operands are captured, the full result is computed into a pending register, and the counter loads N (MULT_CYCLES or DIV_CYCLES).
  - `busy` = (counter != 0), so it is high for exactly N cycles after the accepting edge.
  - On the edge where the counter goes 1→0:
    - hi/lo take the pending result;
    - `done`=1 for the following cycle;
    - `busy` falls in that same cycle.
  - hi/lo hold their old values throughout the busy window.
  - A new `start` can be accepted in the cycle `busy` is 0, i.e. the `done` cycle.
- Multiply:
  - MULT is a signed WIDTH×WIDTH→2·WIDTH product; MULTU is unsigned.
  - {hi,lo} = product.
- Divide:
  - DIV is signed; lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend. DIVU is unsigned.
  - Divide by zero: lo = all ones, hi = dataA. Busy timing is unchanged.
  - Signed overflow (dataA = most-negative, dataB = −1): lo = most-negative, hi = 0.
- State machine:
  - IDLE (counter=0) → RUN on accepting a multi-cycle op.
  - RUN counts down; at 1→0 it commits and returns to IDLE.
  - No other transitions except reset.
- Encodings 110/111 when MDU_MADD_EN is undefined: accepted as no-op. No state change, `busy` stays 0.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 110 MADD: {hi,lo} ← {hi,lo} + signed(dataA)×signed(dataB).
  - op 111 MSUB: {hi,lo} ← {hi,lo} − signed(dataA)×signed(dataB).
  - Both take MULT_CYCLES.
  - The accumulate uses the {hi,lo} value at the accepting edge; the result wraps modulo 2^(2·WIDTH).
- Undefined: 110/111 are no-ops as stated above. No accumulator adder is synthesised.

Test Plan:
- Reset with default params, then MULT dataA=0xFFFFFFFE (−2), dataB=3 → busy high for 5 cycles; done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV −7 / 2:
  - lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1) after 10 busy cycles.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- MTHI 0x1234, then MTLO 0x5678 → hi=0x1234 and lo=0x5678 one edge after each; busy never asserts.
- During MULT busy, pulse start with DIVU 9/3 and MTHI → both ignored; final hi/lo reflect the MULT only. A DIVU started in the done cycle is accepted.
- Mid-DIV (cycle 4), drive reset_n=0 asynchronously → hi=lo=0 and busy=0 immediately. With MDU_MADD_EN defined, hi=0, lo=10, MADD 3×4 → lo=22, hi=0.
